// File: rtl/iterative_multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Imported by the interface, the adder and the top.
package iterative_multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CW    = 6;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_MUL,
    OP_DIV
  } op_t;

  // Multiply wins when both starts arrive together.
  function automatic op_t start_sel(
    input logic m,
    input logic d
  );
    if (m) return OP_MUL;
    if (d) return OP_DIV;
    return OP_NONE;
  endfunction

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] v
  );
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/iterative_multdiv_if.sv
// Operand/control/result bundle between a requester and the multdiv unit.
// The requester is the master; the unit is the slave.
interface iterative_multdiv_if;
  import iterative_multdiv_pkg::*;

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    output ctrl_DIV,
    input  data_result,
    input  data_exception,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    input  ctrl_DIV,
    output data_result,
    output data_exception,
    output data_resultRDY,
    output busy
  );

endinterface

// File: rtl/muldiv_addsub.sv
// 33-bit add/subtract step shared by the Booth multiply
// and the restoring divide iterations.
module muldiv_addsub
  import iterative_multdiv_pkg::*;
(
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/iterative_multdiv.sv
// 32-cycle signed multiply (radix-2 Booth) and divide (restoring
// on magnitudes) sharing one 64-bit work register and one adder.
module iterative_multdiv
  import iterative_multdiv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  iterative_multdiv_if.slave bus
);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic               q_m1;
  logic [WIDTH:0]     as_a;
  logic [WIDTH:0]     as_b;
  logic [WIDTH:0]     as_sum;
  logic               as_sub;
  op_t                sel;
  logic               is_last;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   res_val;
  logic               exc_val;

  assign sel     = start_sel(bus.ctrl_MULT, bus.ctrl_DIV);
  assign mag_b   = mag(op_b);
  assign is_last = (cnt == CW'(ITER - 1));
  assign quo     = prod_nxt[WIDTH-1:0];

  muldiv_addsub u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .sum (as_sum)
  );

  // DIV: {rem, quo} shifts left, trial-subtract |B| from the
  // shifted remainder. MULT: Booth add/sub then arithmetic shift.
  always_comb begin
    as_a     = {prod[63], prod[63:32]};
    as_b     = '0;
    as_sub   = 1'b0;
    prod_nxt = prod;
    if (state == DIV) begin
      as_a     = prod[62:31];
      as_b     = {1'b0, mag_b};
      as_sub   = 1'b1;
      prod_nxt = as_sum[WIDTH]
               ? {prod[62:0], 1'b0}
               : {as_sum[31:0], prod[30:0], 1'b1};
    end else begin
      unique case ({prod[0], q_m1})
        2'b01: as_b = {op_a[31], op_a};
        2'b10: begin
          as_b   = {op_a[31], op_a};
          as_sub = 1'b1;
        end
        default: as_b = '0;
      endcase
      prod_nxt = {as_sum, prod[31:1]};
    end
  end

  always_comb begin
    res_val = quo;
    exc_val = 1'b0;
    if (state == MULT) begin
      exc_val = prod_nxt[63:32] != {WIDTH{prod_nxt[31]}};
    end else if (op_b == '0) begin
      res_val = '0;
      exc_val = 1'b1;
    end else if (op_a == 32'h8000_0000 && op_b == '1) begin
      res_val = 32'h8000_0000;
      exc_val = 1'b1;
    end else if (op_a[31] ^ op_b[31]) begin
      res_val = -quo;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      op_a               <= '0;
      op_b               <= '0;
      prod               <= '0;
      q_m1               <= 1'b0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          if (sel != OP_NONE) begin
            op_a     <= bus.data_operandA;
            op_b     <= bus.data_operandB;
            cnt      <= '0;
            q_m1     <= 1'b0;
            bus.busy <= 1'b1;
            if (sel == OP_MUL) begin
              state <= MULT;
              prod  <= {{WIDTH{1'b0}}, bus.data_operandB};
            end else begin
              state <= DIV;
              prod  <= {{WIDTH{1'b0}}, mag(bus.data_operandA)};
            end
          end
        end
        MULT, DIV: begin
          prod <= prod_nxt;
          q_m1 <= prod[0];
          cnt  <= cnt + 1'b1;
          if (is_last) begin
            state              <= DONE;
            bus.busy           <= 1'b0;
            bus.data_resultRDY <= 1'b1;
            bus.data_result    <= res_val;
            bus.data_exception <= exc_val;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_multdiv.sv
// Scoreboard bench: the driver queues reference results, a monitor
// pops and compares each RDY pulse, including its latency.
module tb_iterative_multdiv;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          start;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];

  iterative_multdiv_if bus ();

  iterative_multdiv dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic void model(input bit m,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] r,
                                output logic e);
    longint p;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 0) begin
      r = 0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = 32'($signed(a) / $signed(b));
      e = 1'b0;
    end
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.data_resultRDY) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdy got=1 want=0");
      end else begin
        e = sb.pop_front();
        chk("result", bus.data_result, e.res);
        chk("exception", 32'(bus.data_exception), 32'(e.exc));
        chk("latency", 32'(cyc - e.start), 32'd32);
        chk("busy_in_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  // Call at a negedge; returns at the negedge after the start edge.
  task automatic issue(input bit m,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input bit both);
    exp_t e;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = m | both;
    bus.ctrl_DIV      = !m | both;
    model(m | both, a, b, e.res, e.exc);
    e.start = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 40; i++) begin
      if (bus.data_resultRDY) return;
      @(negedge clk);
    end
    chk("rdy_timeout", 32'(bus.data_resultRDY), 32'd1);
  endtask

  task automatic run(input bit m,
                     input logic [31:0] a,
                     input logic [31:0] b);
    issue(m, a, b, 1'b0);
    wait_rdy();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_result", bus.data_result, 32'd0);
    chk("rst_exc", 32'(bus.data_exception), 32'd0);
    chk("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    issue(1'b1, 32'd6, 32'd7, 1'b0);
    wait_rdy();
    repeat (2) @(negedge clk);
    chk("hold_result", bus.data_result, 32'd42);
    chk("rdy_one_cycle", 32'(bus.data_resultRDY), 32'd0);

    run(1'b1, -32'sd3, 32'd5);
    run(1'b1, 32'h0001_0000, 32'h0001_0000);
    run(1'b0, 32'd100, 32'd7);
    run(1'b0, -32'sd100, 32'd7);
    run(1'b0, 32'd5, 32'd0);
    run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b1, 32'd9, 32'd11, 1'b1);
    wait_rdy();
    @(negedge clk);

    // DIV pulse during a running MULT must be ignored.
    issue(1'b1, 32'd1234, -32'sd77, 1'b0);
    repeat (9) @(negedge clk);
    bus.data_operandA = 32'd50;
    bus.data_operandB = 32'd5;
    bus.ctrl_DIV = 1'b1;
    @(negedge clk);
    bus.ctrl_DIV = 1'b0;
    wait_rdy();

    // Back-to-back start from the DONE cycle.
    issue(1'b1, -32'sd40000, 32'd70000, 1'b0);
    wait_rdy();
    @(negedge clk);

    // Reset at clock 12 of a DIV drops the operation.
    issue(1'b0, 32'd999, 32'd3, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_result", bus.data_result, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_rdy", 32'(bus.data_resultRDY), 32'd0);
    run(1'b1, 32'd2, 32'd3);

    // Reset beats a simultaneous start.
    rst = 1'b1;
    bus.ctrl_MULT = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ctrl_MULT = 1'b0;
    chk("rst_vs_start_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("rst_vs_start_idle", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        1: begin
          a = 32'($signed($urandom_range(0, 200)) - 100);
          b = 32'($signed($urandom_range(0, 200)) - 100);
        end
        2: b = 32'($urandom_range(0, 2)) - 32'd1;
        3: b = b >> $urandom_range(8, 31);
        default: ;
      endcase
      run(1'($urandom_range(0, 1)), a, b);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iterative_multdiv.md
ITERATIVE_MULTDIV -- requirements
Module: iterative_multdiv

Interface
REQ-001 SHALL use a single clock domain with synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002 SHALL provide these ports (name  direction  width  meaning):
- clock  in  1  master clock, rising edge.
- reset  in  1  synchronous active-high reset.
- data_operandA  in  32  signed multiplicand or dividend, sampled only on the start edge.
- data_operandB  in  32  signed multiplier or divisor, sampled only on the start edge.
- ctrl_MULT  in  1  start-multiply pulse.
- ctrl_DIV  in  1  start-divide pulse.
- data_result  out  32  signed result, registered.
- data_exception  out  1  overflow or divide-by-zero flag, registered.
- data_resultRDY  out  1  one-cycle result-valid pulse.
- busy  out  1  high while an operation is in flight.

Function
REQ-003 SHALL have FSM states IDLE, MULT, DIV and DONE.
REQ-004 SHALL handle a start as follows:
- Start accepted only in IDLE or DONE.
- On an accepting edge: ctrl_MULT moves to MULT, ctrl_DIV moves to DIV.
- If both are high, MULT wins.
- Operands are latched and the iteration counter is cleared on that edge.
REQ-005 SHALL ignore start pulses while in MULT or DIV; there is no queueing and no side effect.
REQ-006 SHALL compute multiply by radix-2 shift-add (or Booth) over exactly 32 iterations, one per clock, using a 64-bit product register.
REQ-007 SHALL compute divide as restoring or non-restoring division on operand magnitudes over exactly 32 iterations, one per clock. The quotient sign is A[31] XOR B[31]; the quotient truncates toward zero; the remainder is discarded.
REQ-008 SHALL perform the 32nd iteration on the 32nd rising edge after the start edge, and enter DONE on that edge.
REQ-009 SHALL hold data_resultRDY high for exactly the one cycle spent in DONE, so RDY is visible 32 clocks after the start edge.
REQ-010 SHALL return to IDLE from DONE on the next edge, unless a new start is accepted on that edge.
REQ-011 SHALL, on multiply, set data_result to product[31:0]. data_exception is 1 when product[63:32] is not the sign-extension of product[31].
REQ-012 SHALL, on divide by zero, return data_result=0 and data_exception=1 after the full 32-cycle latency.
REQ-013 SHALL, on 0x80000000 / -1, return data_result=0x80000000 and data_exception=1.
REQ-014 SHALL hold data_result and data_exception unchanged outside DONE until the next DONE overwrites them.
REQ-015 SHALL drive busy=1 exactly in the MULT and DIV states.
REQ-016 SHALL keep the iteration counter at 6 bits and saturate-free: it is cleared on start and never wraps within an operation.

Reset
REQ-017 SHALL, on reset=1 at a rising edge, force state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0 and busy=0.
REQ-018 SHALL abort any in-flight operation on reset: no RDY pulse is produced for it.
REQ-019 SHALL give reset priority over a simultaneous ctrl_MULT or ctrl_DIV; the start is dropped.

Structure
REQ-020 SHALL place the following in a shared package: WIDTH=32, ITER=32, the state encoding (IDLE, MULT, DIV, DONE) and the operation-select constants.
REQ-021 SHALL isolate the 33-bit add/subtract step in one sub-module, muldiv_addsub, instantiated once and shared by MULT and DIV.
REQ-022 SHALL use no combinational path from any input to data_result, data_exception or data_resultRDY.

Verification
REQ-023 SHALL be covered by a bench with these directed scenarios:
- Multiply: ctrl_MULT with A=6, B=7 -> RDY exactly 32 clocks after the start edge; result=42, exception=0.
- Signed multiply and overflow:
  - A=-3, B=5 -> result=0xFFFFFFF1, exception=0.
  - A=0x00010000, B=0x00010000 -> result=0, exception=1.
- Divide: A=100, B=7 -> result=14; A=-100, B=7 -> result=0xFFFFFFF2 (-14); exception=0 in both cases.
- Divide exceptions:
  - A=5, B=0 -> result=0, exception=1, RDY at 32 clocks.
  - A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
- Start rules:
  - ctrl_DIV pulsed at clock 10 of a running MULT -> ignored; the MULT result is correct and only one RDY pulse occurs.
  - ctrl_MULT in the DONE cycle -> new operation accepted; its RDY follows 32 clocks later.
- Reset mid-operation: reset at clock 12 of a DIV -> busy=0, RDY never asserts, result=0; a following MULT 2*3 returns 6.
